id_ex_stage_register: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS datapath.
- Captures decode-stage operands, including the 32-bit immediate from the sign-extension unit, and presents them to EX one cycle later.
- Contains the load-use hazard detector: it inserts a bubble into EX and asserts a stall to PC and IF/ID.
- Also honours a branch flush and a global hold, and counts inserted bubbles.

---
 rtl/id_ex_stage_register.sv | 104 ++++++++++
 tb/tb_id_ex_stage_register.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register for the 5-stage MIPS datapath.
// Carries decode operands into EX, detects load-use hazards, inserts bubbles on
// hazard or branch flush, freezes on a global hold and counts inserted bubbles.
module id_ex_stage_register #(
    parameter int unsigned CTRL_W  = 8,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               ID_Valid,
    input  logic [31:0]        ID_PC,
    input  logic [31:0]        ID_ReadData1,
    input  logic [31:0]        ID_ReadData2,
    input  logic [31:0]        ID_SignExtImm,
    input  logic [4:0]         ID_Rs,
    input  logic [4:0]         ID_Rt,
    input  logic [4:0]         ID_Rd,
    input  logic               ID_UsesRt,
    input  logic               ID_MemRead,
    input  logic               ID_RegWrite,
    input  logic [CTRL_W-1:0]  ID_Ctrl,
    input  logic               Flush,
    input  logic               Hold,
    output logic               EX_Valid,
    output logic [31:0]        EX_PC,
    output logic [31:0]        EX_ReadData1,
    output logic [31:0]        EX_ReadData2,
    output logic [31:0]        EX_SignExtImm,
    output logic [4:0]         EX_Rs,
    output logic [4:0]         EX_Rt,
    output logic [4:0]         EX_Rd,
    output logic               EX_UsesRt,
    output logic               EX_MemRead,
    output logic               EX_RegWrite,
    output logic [CTRL_W-1:0]  EX_Ctrl,
    output logic               Hazard_Stall,
    output logic [COUNT_W-1:0] BubbleCount
);

    logic raw;
    logic bubble;
    logic count_max;

    // Load-use detection: a valid load in EX writes a register the ID instruction reads.
    always_comb begin
        raw = ID_Valid & EX_Valid & EX_MemRead & (EX_Rt != 5'd0) &
              ((EX_Rt == ID_Rs) | (ID_UsesRt & (EX_Rt == ID_Rt)));
        // Forced low during reset so PC/IF-ID see no stall while the pipe is cleared.
        Hazard_Stall = Reset & raw & ~Flush & ~Hold;
        bubble       = Flush | Hazard_Stall;
        count_max    = &BubbleCount;
    end

    // Pipeline register: hold > flush/hazard bubble > normal load.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            EX_Valid      <= 1'b0;
            EX_PC         <= '0;
            EX_ReadData1  <= '0;
            EX_ReadData2  <= '0;
            EX_SignExtImm <= '0;
            EX_Rs         <= '0;
            EX_Rt         <= '0;
            EX_Rd         <= '0;
            EX_UsesRt     <= 1'b0;
            EX_MemRead    <= 1'b0;
            EX_RegWrite   <= 1'b0;
            EX_Ctrl       <= '0;
            BubbleCount   <= '0;
        end else if (Hold) begin
            // Freeze everything; a pending flush is re-presented once Hold drops.
        end else if (bubble) begin
            EX_Valid      <= 1'b0;
            EX_PC         <= '0;
            EX_ReadData1  <= '0;
            EX_ReadData2  <= '0;
            EX_SignExtImm <= '0;
            EX_Rs         <= '0;
            EX_Rt         <= '0;
            EX_Rd         <= '0;
            EX_UsesRt     <= 1'b0;
            EX_MemRead    <= 1'b0;
            EX_RegWrite   <= 1'b0;
            EX_Ctrl       <= '0;
            if (!count_max) begin
                BubbleCount <= BubbleCount + COUNT_W'(1);
            end
        end else begin
            EX_Valid      <= ID_Valid;
            EX_PC         <= ID_PC;
            EX_ReadData1  <= ID_ReadData1;
            EX_ReadData2  <= ID_ReadData2;
            EX_SignExtImm <= ID_SignExtImm;
            EX_Rs         <= ID_Rs;
            EX_Rt         <= ID_Rt;
            EX_Rd         <= ID_Rd;
            EX_UsesRt     <= ID_UsesRt;
            EX_MemRead    <= ID_MemRead;
            EX_RegWrite   <= ID_RegWrite;
            EX_Ctrl       <= ID_Ctrl;
        end
    end

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Randomized bench for id_ex_stage_register against a behavioural model of the stage.
module tb_id_ex_stage_register;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        uses_rt;
        logic        mem_read;
        logic        reg_write;
        logic [7:0]  ctrl;
    } instr_t;

    logic   Clk = 1'b0;
    logic   Reset = 1'b0;
    logic   Flush = 1'b0;
    logic   Hold = 1'b0;
    instr_t id_in = '0;

    instr_t      ex_obs, ex_obs_s;
    logic        stall, stall_s;
    logic [15:0] bcount;
    logic [1:0]  bcount_s;

    // Model state
    instr_t m_ex = '0;
    int     m_cnt = 0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clk = ~Clk;

    id_ex_stage_register #(.CTRL_W(8), .COUNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset),
        .ID_Valid(id_in.valid), .ID_PC(id_in.pc), .ID_ReadData1(id_in.rd1),
        .ID_ReadData2(id_in.rd2), .ID_SignExtImm(id_in.imm),
        .ID_Rs(id_in.rs), .ID_Rt(id_in.rt), .ID_Rd(id_in.rd),
        .ID_UsesRt(id_in.uses_rt), .ID_MemRead(id_in.mem_read),
        .ID_RegWrite(id_in.reg_write), .ID_Ctrl(id_in.ctrl),
        .Flush(Flush), .Hold(Hold),
        .EX_Valid(ex_obs.valid), .EX_PC(ex_obs.pc), .EX_ReadData1(ex_obs.rd1),
        .EX_ReadData2(ex_obs.rd2), .EX_SignExtImm(ex_obs.imm),
        .EX_Rs(ex_obs.rs), .EX_Rt(ex_obs.rt), .EX_Rd(ex_obs.rd),
        .EX_UsesRt(ex_obs.uses_rt), .EX_MemRead(ex_obs.mem_read),
        .EX_RegWrite(ex_obs.reg_write), .EX_Ctrl(ex_obs.ctrl),
        .Hazard_Stall(stall), .BubbleCount(bcount)
    );

    // Narrow-counter instance to reach saturation quickly.
    id_ex_stage_register #(.CTRL_W(8), .COUNT_W(2)) dut_small (
        .Clk(Clk), .Reset(Reset),
        .ID_Valid(id_in.valid), .ID_PC(id_in.pc), .ID_ReadData1(id_in.rd1),
        .ID_ReadData2(id_in.rd2), .ID_SignExtImm(id_in.imm),
        .ID_Rs(id_in.rs), .ID_Rt(id_in.rt), .ID_Rd(id_in.rd),
        .ID_UsesRt(id_in.uses_rt), .ID_MemRead(id_in.mem_read),
        .ID_RegWrite(id_in.reg_write), .ID_Ctrl(id_in.ctrl),
        .Flush(Flush), .Hold(Hold),
        .EX_Valid(ex_obs_s.valid), .EX_PC(ex_obs_s.pc), .EX_ReadData1(ex_obs_s.rd1),
        .EX_ReadData2(ex_obs_s.rd2), .EX_SignExtImm(ex_obs_s.imm),
        .EX_Rs(ex_obs_s.rs), .EX_Rt(ex_obs_s.rt), .EX_Rd(ex_obs_s.rd),
        .EX_UsesRt(ex_obs_s.uses_rt), .EX_MemRead(ex_obs_s.mem_read),
        .EX_RegWrite(ex_obs_s.reg_write), .EX_Ctrl(ex_obs_s.ctrl),
        .Hazard_Stall(stall_s), .BubbleCount(bcount_s)
    );

    task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // A load in EX followed by a reader of its destination must wait one cycle.
    function automatic logic model_stall(input instr_t ex, input instr_t id, input logic f,
                                         input logic h);
        logic dep;
        dep = ex.valid && ex.mem_read && ex.rt != 0 && id.valid &&
              (id.rs == ex.rt || (id.uses_rt && id.rt == ex.rt));
        return dep && !f && !h;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check_state(input string tag);
        check_eq({tag, ".ex"}, 160'(ex_obs), 160'(m_ex));
        check_eq({tag, ".ex_s"}, 160'(ex_obs_s), 160'(m_ex));
        check_eq({tag, ".cnt"}, 160'(bcount), 160'(sat(m_cnt, 65535)));
        check_eq({tag, ".cnt_s"}, 160'(bcount_s), 160'(sat(m_cnt, 3)));
    endtask

    // Present one ID slot, check the stall before the edge and the EX state after it.
    task automatic apply(input string tag, input instr_t id, input logic f, input logic h);
        logic s;
        id_in = id;
        Flush = f;
        Hold  = h;
        #1;
        s = model_stall(m_ex, id, f, h);
        check_eq({tag, ".stall"}, 160'(stall), 160'(s));
        @(posedge Clk);
        if (!h) begin
            if (f || s) begin
                m_ex = '0;
                m_cnt++;
            end else begin
                m_ex = id;
            end
        end
        #1;
        check_state(tag);
    endtask

    function automatic instr_t rand_instr();
        instr_t r;
        r.valid     = ($urandom_range(0, 7) != 0);
        r.pc        = $urandom;
        r.rd1       = $urandom;
        r.rd2       = $urandom;
        r.imm       = $urandom;
        r.rs        = 5'($urandom_range(0, 3));
        r.rt        = 5'($urandom_range(0, 3));
        r.rd        = 5'($urandom);
        r.uses_rt   = 1'($urandom);
        r.mem_read  = 1'($urandom);
        r.reg_write = 1'($urandom);
        r.ctrl      = 8'($urandom);
        return r;
    endfunction

    instr_t lw, use_i, blank;

    initial begin
        blank = '0;
        // Reset asserted from time zero.
        #3;
        check_state("reset");
        check_eq("reset.stall", 160'(stall), 160'(0));
        @(posedge Clk);
        #1 Reset = 1'b1;

        // Plain load.
        lw = '0;
        lw.valid = 1'b1;
        lw.pc    = 32'h0000_0004;
        lw.imm   = 32'hFFFF_FFFC;
        lw.rs    = 5'd1;
        apply("plain", lw, 1'b0, 1'b0);
        check_eq("plain.imm", 160'(ex_obs.imm), 160'(32'hFFFF_FFFC));
        check_eq("plain.cnt0", 160'(bcount), 160'(0));

        // Load-use on rs.
        lw = '0;
        lw.valid = 1'b1; lw.mem_read = 1'b1; lw.reg_write = 1'b1; lw.rt = 5'd8;
        lw.ctrl = 8'h5A;
        apply("lw", lw, 1'b0, 1'b0);
        use_i = '0;
        use_i.valid = 1'b1; use_i.rs = 5'd8; use_i.rt = 5'd3; use_i.uses_rt = 1'b1;
        use_i.reg_write = 1'b1; use_i.ctrl = 8'hC3; use_i.pc = 32'h10;
        #1 id_in = use_i;
        #1 check_eq("lu.stall_now", 160'(stall), 160'(1));
        apply("lu.bubble", use_i, 1'b0, 1'b0);
        check_eq("lu.bubble_valid", 160'(ex_obs.valid), 160'(0));
        check_eq("lu.bubble_cnt", 160'(bcount), 160'(1));
        apply("lu.retry", use_i, 1'b0, 1'b0);
        check_eq("lu.retry_pc", 160'(ex_obs.pc), 160'(32'h10));

        // $zero load never stalls.
        lw.rt = 5'd0;
        apply("z.lw", lw, 1'b0, 1'b0);
        use_i.rs = 5'd0;
        apply("z.use", use_i, 1'b0, 1'b0);
        // rt match without rt use.
        lw.rt = 5'd9;
        apply("nrt.lw", lw, 1'b0, 1'b0);
        use_i.rs = 5'd4; use_i.rt = 5'd9; use_i.uses_rt = 1'b0;
        apply("nrt.use", use_i, 1'b0, 1'b0);

        // Flush beats hazard: one bubble only.
        apply("fp.lw", lw, 1'b0, 1'b0);
        use_i.rs = 5'd9;
        apply("fp.flush", use_i, 1'b1, 1'b0);

        // Hold for three cycles with changing inputs, then hold with flush.
        apply("h.load", use_i, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) apply("h.hold", rand_instr(), 1'b0, 1'b1);
        apply("hf.hold", rand_instr(), 1'b1, 1'b1);
        apply("hf.hold2", rand_instr(), 1'b1, 1'b1);
        apply("hf.flush", rand_instr(), 1'b1, 1'b0);

        // Async reset between edges.
        apply("ar.load", use_i, 1'b0, 1'b0);
        #2 Reset = 1'b0;
        #1;
        m_ex = '0;
        m_cnt = 0;
        check_state("ar.async");
        check_eq("ar.stall", 160'(stall), 160'(0));
        #1 Reset = 1'b1;

        // Five flushes saturate the narrow counter at 3.
        for (int i = 0; i < 5; i++) apply("sat.flush", rand_instr(), 1'b1, 1'b0);
        check_eq("sat.small", 160'(bcount_s), 160'(3));
        check_eq("sat.wide", 160'(bcount), 160'(5));

        // Randomized traffic; bias toward retrying the stalled instruction as IF/ID would.
        use_i = rand_instr();
        for (int i = 0; i < 400; i++) begin
            logic f, h, s;
            f = ($urandom_range(0, 9) == 0);
            h = ($urandom_range(0, 9) == 0);
            s = model_stall(m_ex, use_i, f, h);
            apply("rnd", use_i, f, h);
            if (!s && !h) use_i = rand_instr();
        end

        apply("end", blank, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
